time_set_sequencer: RTL and testbench
=====================================

// Module: time_set_sequencer
// PURPOSE
//   Time-setting mode controller for the digital clock. Sequences RUN -> SET_HOUR -> SET_MIN -> RUN
//   on Set presses and gates the hour/minute/second counter enables. Converts a held Up button into
//   increment pulses with auto-repeat, and drives the display blink and dot enables.
//   Returns to RUN automatically after an inactivity timeout.
// PARAMETERS
//   CLK_FREQ_HZ      32768  i_Clock frequency in Hz
//   REPEAT_DELAY_MS  500    Up hold time before auto-repeat starts
//   REPEAT_RATE_MS   150    auto-repeat period after the delay
//   TIMEOUT_S        10     i_Enable_1Hz ticks without activity before forced return to RUN; must be >= 1
//   Derived: DELAY_CYC = CLK_FREQ_HZ*REPEAT_DELAY_MS/1000, RATE_CYC = CLK_FREQ_HZ*REPEAT_RATE_MS/1000.
//   Both must be >= 2. Counter widths come from $clog2.
// PORTS
//   i_Clock                  in   1  system clock
//   i_Reset_n                in   1  asynchronous active-low reset
//   i_Enable_1Hz             in   1  one-cycle 1 Hz tick
//   i_Press_Set              in   1  one-cycle pulse: Set button released (debounced)
//   i_Up_Held                in   1  debounced, synchronized Up button level (1 = pressed)
//   o_Counters_Reset         out  1  one-cycle pulse: clear the seconds counter
//   o_Enable_Increment       out  1  one-cycle increment pulse to the selected counter
//   o_Enable_Count           out  3  counter enables {hour, min, sec}
//   o_Display_Enable_Digits  out  2  blink enables: [1] = hour digit pair, [0] = minute digit pair
//   o_Display_Enable_Dot     out  1  colon/dot blink enable
//   o_Mode                   out  2  current state: 00 = RUN, 01 = SET_HOUR, 10 = SET_MIN
// BEHAVIOUR
//   Reset
//   - All outputs and counters are registered and are asynchronously reset when i_Reset_n = 0.
//   - Reset values: state RUN, o_Enable_Count = 3'b001, o_Display_Enable_Digits = 2'b00,
//     o_Display_Enable_Dot = 1, all pulse outputs 0, all counters 0.
//   State table (encoding = o_Mode); outputs are registered and follow the state
//   - RUN:      Enable_Count = 001, Digits = 00, Dot = 1.
//   - SET_HOUR: Enable_Count = 100, Digits = 10, Dot = 0.
//   - SET_MIN:  Enable_Count = 010, Digits = 01, Dot = 0.
//   Transitions on i_Press_Set (each takes effect one cycle after the pulse)
//   - RUN -> SET_HOUR.
//   - SET_HOUR -> SET_MIN.
//   - SET_MIN -> RUN. o_Counters_Reset pulses for 1 cycle, in the same cycle o_Mode becomes 00.
//   Timeout
//   - Active in SET states only. The timeout counter clears on any i_Press_Set, any i_Up_Held
//     rising edge, and on state entry.
//   - The counter increments on i_Enable_1Hz. While i_Up_Held = 1 the counter is held at 0.
//   - When the count reaches TIMEOUT_S, the next state is RUN. There is no o_Counters_Reset pulse on timeout.
//   Auto-repeat (SET states only)
//   - i_Up_Held rising edge -> o_Enable_Increment pulses for 1 cycle, on the following cycle.
//   - Hold continues -> a further pulse after DELAY_CYC cycles measured from the edge pulse, then
//     one pulse every RATE_CYC cycles.
//   - Release at any point stops pulses and clears the repeat counter immediately.
//   - In RUN, o_Enable_Increment is held at 0 and a held Up button is ignored.
//   Simultaneous events
//   - i_Press_Set together with an Up edge or a repeat expiry: Set wins and no increment is issued.
//   - The repeat counter restarts. A still-held Up produces no pulses in the new state until it is
//     released and pressed again.
//   - i_Press_Set together with a timeout expiry: the Set transition is taken (timeout is ignored).
//   - An i_Enable_1Hz tick is only a timebase. It never generates o_Enable_Increment.
//   Reset mid-operation returns to RUN immediately with the reset values above; no pulse is emitted.
// TESTING  (CLK_FREQ_HZ=1000, REPEAT_DELAY_MS=20, REPEAT_RATE_MS=5, TIMEOUT_S=3)
//   1. After reset, 3 Set pulses -> o_Mode = 01, 10, 00 in turn. The Enable_Count/Digits/Dot values
//      match the state table, and exactly one o_Counters_Reset pulse occurs, coincident with o_Mode = 00.
//   2. In SET_HOUR, Up held for 40 cycles -> 5 increment pulses: at edge+1, +21, +26, +31, +36.
//      After release, no more pulses.
//   3. In RUN, Up held for 100 cycles -> o_Enable_Increment stays 0 and o_Mode stays 00.
//   4. In SET_MIN with no activity, 3 i_Enable_1Hz ticks -> o_Mode = 00 one cycle after the third
//      tick and no o_Counters_Reset pulse. Repeat with Up held across the ticks -> mode stays 10.
//   5. A Set pulse in the same cycle as an Up rising edge in SET_HOUR -> o_Mode = 10 and no increment
//      pulse. Up is still held for 30 more cycles -> 0 pulses.
//   6. Reset asserted during auto-repeat in SET_MIN -> all outputs take reset values asynchronously.
//      After release, o_Mode = 00 and there are no pulses.

Source files
------------

// File: rtl/time_set_sequencer.sv
// -----------------------------------------------------------------------------
// time_set_sequencer
// Time-setting mode controller for the digital clock. A Set press steps the
// mode RUN -> SET_HOUR -> SET_MIN -> RUN. The controller gates the
// hour/minute/second counter enables and turns a held Up button into increment
// pulses with auto-repeat. It also drives the display blink and dot enables.
// An inactivity timeout drops back to RUN.
//
// Ports
//   i_Clock                  system clock
//   i_Reset_n                asynchronous active-low reset
//   i_Enable_1Hz             one-cycle 1 Hz tick (timeout timebase only)
//   i_Press_Set              one-cycle Set pulse
//   i_Up_Held                debounced Up level
//   o_Counters_Reset         one-cycle clear of the seconds counter (SET_MIN -> RUN)
//   o_Enable_Increment       one-cycle increment pulse to the selected counter
//   o_Enable_Count           counter enables {hour, min, sec}
//   o_Display_Enable_Digits  blink enables {hour pair, minute pair}
//   o_Display_Enable_Dot     colon/dot enable
//   o_Mode                   00 RUN, 01 SET_HOUR, 10 SET_MIN
// -----------------------------------------------------------------------------
module time_set_sequencer #(
   parameter int CLK_FREQ_HZ     = 32768,
   parameter int REPEAT_DELAY_MS = 500,
   parameter int REPEAT_RATE_MS  = 150,
   parameter int TIMEOUT_S       = 10
) (
   input  logic       i_Clock,
   input  logic       i_Reset_n,
   input  logic       i_Enable_1Hz,
   input  logic       i_Press_Set,
   input  logic       i_Up_Held,
   output logic       o_Counters_Reset,
   output logic       o_Enable_Increment,
   output logic [2:0] o_Enable_Count,
   output logic [1:0] o_Display_Enable_Digits,
   output logic       o_Display_Enable_Dot,
   output logic [1:0] o_Mode
);

   localparam int DELAY_CYC = CLK_FREQ_HZ * REPEAT_DELAY_MS / 1000;
   localparam int RATE_CYC  = CLK_FREQ_HZ * REPEAT_RATE_MS / 1000;
   localparam int RPT_MAX   = (DELAY_CYC > RATE_CYC) ? DELAY_CYC : RATE_CYC;
   localparam int RW        = $clog2(RPT_MAX);
   localparam int TW        = $clog2(TIMEOUT_S + 1);

   localparam logic [RW-1:0] DELAY_LAST = RW'(DELAY_CYC - 1);
   localparam logic [RW-1:0] RATE_LAST  = RW'(RATE_CYC - 1);
   localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT_S - 1);

   typedef enum logic [1:0] {
      ST_RUN      = 2'b00,
      ST_SET_HOUR = 2'b01,
      ST_SET_MIN  = 2'b10
   } state_t;

   state_t          state_r;
   state_t          state_nx_s;
   logic            crst_nx_s;
   logic [2:0]      cnt_en_nx_s;
   logic [1:0]      digits_nx_s;
   logic            dot_nx_s;
   logic            up_d_r;
   logic            up_rise_s;
   logic [TW-1:0]   tmo_r;
   logic            tmo_hit_s;
   logic [RW-1:0]   rpt_cnt_r;
   logic            rpt_phase_r;   // 0: waiting initial delay, 1: steady repeat rate
   logic            rpt_armed_r;   // current Up hold started with a valid edge in a SET state
   logic            rpt_expire_s;
   logic            inc_r;
   logic            crst_r;
   logic [2:0]      cnt_en_r;
   logic [1:0]      digits_r;
   logic            dot_r;

   assign up_rise_s    = i_Up_Held & ~up_d_r;
   // The count "reaches" TIMEOUT_S on the tick that would take it there, so the
   // mode drops to RUN one cycle after that tick.
   assign tmo_hit_s    = (state_r != ST_RUN) & i_Enable_1Hz & ~i_Up_Held & (tmo_r == TMO_LAST);
   assign rpt_expire_s = rpt_phase_r ? (rpt_cnt_r == RATE_LAST) : (rpt_cnt_r == DELAY_LAST);

   // Mode state register.
   always_ff @(posedge i_Clock or negedge i_Reset_n) begin
      if (!i_Reset_n) begin
         state_r <= ST_RUN;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // Next mode: Set has priority over the inactivity timeout.
   always_comb begin
      state_nx_s = state_r;
      crst_nx_s  = 1'b0;
      case (state_r)
         ST_RUN: begin
            if (i_Press_Set) state_nx_s = ST_SET_HOUR;
            else             state_nx_s = ST_RUN;
         end
         ST_SET_HOUR: begin
            if (i_Press_Set)    state_nx_s = ST_SET_MIN;
            else if (tmo_hit_s) state_nx_s = ST_RUN;
            else                state_nx_s = ST_SET_HOUR;
         end
         ST_SET_MIN: begin
            if (i_Press_Set) begin
               state_nx_s = ST_RUN;
               crst_nx_s  = 1'b1;
            end else if (tmo_hit_s) begin
               state_nx_s = ST_RUN;
            end else begin
               state_nx_s = ST_SET_MIN;
            end
         end
         default: state_nx_s = ST_RUN;
      endcase
   end

   // Enable/blink decode of the upcoming mode so the registered copies line up with o_Mode.
   always_comb begin
      cnt_en_nx_s = 3'b001;
      digits_nx_s = 2'b00;
      dot_nx_s    = 1'b1;
      case (state_nx_s)
         ST_RUN:      begin cnt_en_nx_s = 3'b001; digits_nx_s = 2'b00; dot_nx_s = 1'b1; end
         ST_SET_HOUR: begin cnt_en_nx_s = 3'b100; digits_nx_s = 2'b10; dot_nx_s = 1'b0; end
         ST_SET_MIN:  begin cnt_en_nx_s = 3'b010; digits_nx_s = 2'b01; dot_nx_s = 1'b0; end
         default:     begin cnt_en_nx_s = 3'b001; digits_nx_s = 2'b00; dot_nx_s = 1'b1; end
      endcase
   end

   // Registered display/enable outputs and the seconds-clear pulse.
   always_ff @(posedge i_Clock or negedge i_Reset_n) begin
      if (!i_Reset_n) begin
         cnt_en_r <= 3'b001;
         digits_r <= 2'b00;
         dot_r    <= 1'b1;
         crst_r   <= 1'b0;
      end else begin
         cnt_en_r <= cnt_en_nx_s;
         digits_r <= digits_nx_s;
         dot_r    <= dot_nx_s;
         crst_r   <= crst_nx_s;
      end
   end

   // Up level history for edge detection.
   always_ff @(posedge i_Clock or negedge i_Reset_n) begin
      if (!i_Reset_n) begin
         up_d_r <= 1'b0;
      end else begin
         up_d_r <= i_Up_Held;
      end
   end

   // Inactivity timer: counts 1 Hz ticks in SET modes. Any Set or held Up keeps it at zero.
   // Every entry into a SET mode comes from a Set press, so this also clears it on entry.
   always_ff @(posedge i_Clock or negedge i_Reset_n) begin
      if (!i_Reset_n) begin
         tmo_r <= {TW{1'b0}};
      end else if ((state_r == ST_RUN) || i_Press_Set || i_Up_Held || tmo_hit_s) begin
         tmo_r <= {TW{1'b0}};
      end else if (i_Enable_1Hz) begin
         tmo_r <= tmo_r + TW'(1);
      end else begin
         tmo_r <= tmo_r;
      end
   end

   // Auto-repeat: edge pulse, then one pulse after DELAY_CYC, then one every RATE_CYC.
   // A Set press disarms the hold, so a button still held into the new mode stays silent.
   always_ff @(posedge i_Clock or negedge i_Reset_n) begin
      if (!i_Reset_n) begin
         rpt_cnt_r   <= {RW{1'b0}};
         rpt_phase_r <= 1'b0;
         rpt_armed_r <= 1'b0;
         inc_r       <= 1'b0;
      end else if ((state_r == ST_RUN) || i_Press_Set || !i_Up_Held) begin
         rpt_cnt_r   <= {RW{1'b0}};
         rpt_phase_r <= 1'b0;
         rpt_armed_r <= 1'b0;
         inc_r       <= 1'b0;
      end else if (up_rise_s) begin
         rpt_cnt_r   <= {RW{1'b0}};
         rpt_phase_r <= 1'b0;
         rpt_armed_r <= 1'b1;
         inc_r       <= 1'b1;
      end else if (rpt_armed_r && rpt_expire_s) begin
         rpt_cnt_r   <= {RW{1'b0}};
         rpt_phase_r <= 1'b1;
         rpt_armed_r <= 1'b1;
         inc_r       <= 1'b1;
      end else if (rpt_armed_r) begin
         rpt_cnt_r   <= rpt_cnt_r + RW'(1);
         rpt_phase_r <= rpt_phase_r;
         rpt_armed_r <= 1'b1;
         inc_r       <= 1'b0;
      end else begin
         rpt_cnt_r   <= {RW{1'b0}};
         rpt_phase_r <= 1'b0;
         rpt_armed_r <= 1'b0;
         inc_r       <= 1'b0;
      end
   end

   assign o_Mode                  = state_r;
   assign o_Enable_Count          = cnt_en_r;
   assign o_Display_Enable_Digits = digits_r;
   assign o_Display_Enable_Dot    = dot_r;
   assign o_Enable_Increment      = inc_r;
   assign o_Counters_Reset        = crst_r;

endmodule

// File: tb/tb_time_set_sequencer.sv
// Directed bench for time_set_sequencer with a 1 kHz clock, a 20-cycle repeat
// delay, a 5-cycle repeat rate and a 3-tick timeout. Each step drives inputs
// for one cycle and checks every output just after the consuming clock edge.
module tb_time_set_sequencer;

   logic       clk;
   logic       rst_n;
   logic       tick;
   logic       set_p;
   logic       up;
   logic       crst;
   logic       inc;
   logic [2:0] cnt_en;
   logic [1:0] digits;
   logic       dot;
   logic [1:0] mode;

   int n_vec;
   int n_err;

   typedef struct {
      logic       set;
      logic       up;
      logic       tick;
      logic [1:0] mode;
      logic       inc;
      logic       crst;
   } vec_t;

   vec_t vt [0:22];

   time_set_sequencer #(
      .CLK_FREQ_HZ    (1000),
      .REPEAT_DELAY_MS(20),
      .REPEAT_RATE_MS (5),
      .TIMEOUT_S      (3)
   ) dut (
      .i_Clock                (clk),
      .i_Reset_n              (rst_n),
      .i_Enable_1Hz           (tick),
      .i_Press_Set            (set_p),
      .i_Up_Held              (up),
      .o_Counters_Reset       (crst),
      .o_Enable_Increment     (inc),
      .o_Enable_Count         (cnt_en),
      .o_Display_Enable_Digits(digits),
      .o_Display_Enable_Dot   (dot),
      .o_Mode                 (mode)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected outputs packed {mode, enables, digits, dot, inc, crst}.
   function automatic logic [9:0] exp_out(input logic [1:0] m, input logic i, input logic c);
      logic [7:0] s;
      case (m)
         2'b00:   s = {2'b00, 3'b001, 2'b00, 1'b1};
         2'b01:   s = {2'b01, 3'b100, 2'b10, 1'b0};
         2'b10:   s = {2'b10, 3'b010, 2'b01, 1'b0};
         default: s = 8'hxx;
      endcase
      return {s, i, c};
   endfunction

   // Increment pulses of a hold, indexed by steps after the rising edge.
   function automatic logic rpt_pulse(input int i);
      return (i == 0) || (i >= 20 && ((i - 20) % 5) == 0);
   endfunction

   task automatic chk(input string name, input logic [1:0] m, input logic i, input logic c);
      logic [9:0] act;
      logic [9:0] exp;
      act = {mode, cnt_en, digits, dot, inc, crst};
      exp = exp_out(m, i, c);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %b expected %b (mode,en,dig,dot,inc,crst)", name, act, exp);
      end
   endtask

   task automatic step(input logic s, input logic u, input logic t);
      set_p = s;
      up    = u;
      tick  = t;
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      rst_n = 1'b0;
      tick  = 1'b0;
      set_p = 1'b0;
      up    = 1'b0;

      //            set   up    tick  mode   inc   crst
      vt[0]  = '{1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};
      vt[1]  = '{1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0};
      vt[2]  = '{1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0};
      vt[3]  = '{1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0};
      vt[4]  = '{1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1};
      vt[5]  = '{1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};
      vt[6]  = '{1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0};
      vt[7]  = '{1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0};
      vt[8]  = '{1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0};
      vt[9]  = '{1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0};
      vt[10] = '{1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0};
      vt[11] = '{1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0};
      vt[12] = '{1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0};
      vt[13] = '{1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0};
      vt[14] = '{1'b0, 1'b1, 1'b0, 2'b10, 1'b1, 1'b0};
      vt[15] = '{1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 1'b0};
      vt[16] = '{1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 1'b0};
      vt[17] = '{1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 1'b0};
      vt[18] = '{1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 1'b0};
      vt[19] = '{1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0};
      vt[20] = '{1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0};
      vt[21] = '{1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0};
      vt[22] = '{1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0};

      // Reset values while reset is held.
      #12;
      chk("reset_state", 2'b00, 1'b0, 1'b0);
      #11;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Mode cycling, seconds clear, timeout, and timeout held off by Up.
      for (int k = 0; k < 23; k++) begin
         step(vt[k].set, vt[k].up, vt[k].tick);
         chk($sformatf("table_%0d", k), vt[k].mode, vt[k].inc, vt[k].crst);
      end

      // Auto-repeat in SET_HOUR: 40-cycle hold, then release.
      step(1'b1, 1'b0, 1'b0);
      chk("enter_set_hour", 2'b01, 1'b0, 1'b0);
      for (int i = 0; i < 40; i++) begin
         step(1'b0, 1'b1, 1'b0);
         chk($sformatf("hold40_%0d", i), 2'b01, rpt_pulse(i), 1'b0);
      end
      for (int i = 0; i < 10; i++) begin
         step(1'b0, 1'b0, 1'b0);
         chk($sformatf("release_%0d", i), 2'b01, 1'b0, 1'b0);
      end

      // A short hold then a re-press: the delay restarts from the new edge.
      for (int i = 0; i < 10; i++) begin
         step(1'b0, 1'b1, 1'b0);
         chk($sformatf("short_%0d", i), 2'b01, rpt_pulse(i), 1'b0);
      end
      step(1'b0, 1'b0, 1'b0);
      chk("gap", 2'b01, 1'b0, 1'b0);
      for (int i = 0; i < 25; i++) begin
         step(1'b0, 1'b1, 1'b0);
         chk($sformatf("repress_%0d", i), 2'b01, rpt_pulse(i), 1'b0);
      end
      step(1'b0, 1'b0, 1'b0);
      chk("repress_rel", 2'b01, 1'b0, 1'b0);

      // Back to RUN, then Up held in RUN does nothing.
      step(1'b1, 1'b0, 1'b0);
      chk("to_set_min", 2'b10, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      chk("to_run_crst", 2'b00, 1'b0, 1'b1);
      for (int i = 0; i < 100; i++) begin
         step(1'b0, 1'b1, 1'b0);
         chk($sformatf("run_hold_%0d", i), 2'b00, 1'b0, 1'b0);
      end
      step(1'b0, 1'b0, 1'b0);
      chk("run_release", 2'b00, 1'b0, 1'b0);

      // Set together with an Up edge: Set wins and the held button stays silent.
      step(1'b1, 1'b0, 1'b0);
      chk("sim_enter_hour", 2'b01, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      chk("sim_set_up", 2'b10, 1'b0, 1'b0);
      for (int i = 0; i < 30; i++) begin
         step(1'b0, 1'b1, 1'b0);
         chk($sformatf("sim_hold_%0d", i), 2'b10, 1'b0, 1'b0);
      end
      step(1'b0, 1'b0, 1'b0);
      chk("sim_release", 2'b10, 1'b0, 1'b0);

      // Reset during auto-repeat in SET_MIN.
      for (int i = 0; i < 24; i++) begin
         step(1'b0, 1'b1, 1'b0);
         chk($sformatf("pre_rst_%0d", i), 2'b10, rpt_pulse(i), 1'b0);
      end
      rst_n = 1'b0;
      #2;
      chk("async_reset", 2'b00, 1'b0, 1'b0);
      @(posedge clk);
      @(posedge clk);
      #3;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("post_rst_first", 2'b00, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) begin
         step(1'b0, 1'b1, 1'b0);
         chk($sformatf("post_rst_%0d", i), 2'b00, 1'b0, 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
